// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer datapath blocks.
package layer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Parallel-load register bank; every register loads from its own input when load is high.
module reg_file #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_REGS   = 20
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din  [NUM_REGS],
  output logic [DATA_WIDTH-1:0] dout [NUM_REGS]
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_cell
      logic [DATA_WIDTH-1:0] cell_reg;

      // Contents are deliberately not reset; the consumer ignores them until a load.
      always_ff @(posedge clk) begin
        if (load) begin
          cell_reg <= din[gi];
        end
      end

      assign dout[gi] = cell_reg;
    end
  endgenerate

endmodule

// File: rtl/layer_serializer.sv
// Captures a full layer vector on a single-cycle strobe and streams it out one element
// per beat under valid/ready flow control, flagging vectors that arrive while busy.
module layer_serializer
  import layer_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_NODES  = 20,
  localparam int IDX_W     = idx_width(NUM_NODES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] zin [NUM_NODES],
  output logic                  i_ready,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_last,
  output logic                  o_overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  ser_state_t            state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic                  overflow_reg;
  logic                  capture;
  logic [DATA_WIDTH-1:0] vec_buf [NUM_NODES];

  reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_NODES)
  ) u_buf (
    .clk  (clk),
    .load (capture && !rst),
    .din  (zin),
    .dout (vec_buf)
  );

  assign o_valid    = (state_reg == STREAM);
  assign o_last     = o_valid && (idx_reg == LAST_IDX);
  // Accepting on the final beat lets vectors run back to back without a bubble.
  assign i_ready    = (state_reg == IDLE) || (o_last && o_ready);
  assign capture    = i_valid && i_ready;
  assign o_idx      = idx_reg;
  assign o_data     = vec_buf[idx_reg];
  assign o_overflow = overflow_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    if (capture) begin
      state_next = STREAM;
      idx_next   = '0;
    end else if (o_valid && o_ready) begin
      if (o_last) begin
        state_next = IDLE;
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (i_valid && !i_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench: directed vectors on a 4-node instance plus a long random-stall run at 20 nodes.
module tb_layer_serializer;

  typedef struct {
    logic [23:0] d;
    int          idx;
    bit          last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- 4-node instance ----------------
  logic        rst4, i_valid4, o_ready4;
  logic [23:0] zin4 [4];
  logic        i_ready4, o_valid4, o_last4, o_overflow4;
  logic [23:0] o_data4;
  logic [1:0]  o_idx4;

  layer_serializer #(.DATA_WIDTH(24), .NUM_NODES(4)) dut4 (
    .clk(clk), .rst(rst4), .i_valid(i_valid4), .zin(zin4), .i_ready(i_ready4),
    .o_valid(o_valid4), .o_ready(o_ready4), .o_data(o_data4), .o_idx(o_idx4),
    .o_last(o_last4), .o_overflow(o_overflow4)
  );

  // ---------------- 20-node instance ----------------
  logic        rst20, i_valid20, o_ready20;
  logic [23:0] zin20 [20];
  logic        i_ready20, o_valid20, o_last20, o_overflow20;
  logic [23:0] o_data20;
  logic [4:0]  o_idx20;

  layer_serializer #(.DATA_WIDTH(24), .NUM_NODES(20)) dut20 (
    .clk(clk), .rst(rst20), .i_valid(i_valid20), .zin(zin20), .i_ready(i_ready20),
    .o_valid(o_valid20), .o_ready(o_ready20), .o_data(o_data20), .o_idx(o_idx20),
    .o_last(o_last20), .o_overflow(o_overflow20)
  );

  beat_t q4[$];
  beat_t q20[$];
  beat_t e4, e20;
  int    lasts20   = 0;
  int    max_idx20 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst4 && o_valid4 && o_ready4) begin
      total++;
      if (q4.size() == 0) begin
        bad++;
        $display("FAIL beat4 unexpected: data=%0d idx=%0d last=%0d", o_data4, o_idx4, o_last4);
      end else begin
        e4 = q4.pop_front();
        if (o_data4 !== e4.d || o_idx4 !== 2'(e4.idx) || o_last4 !== e4.last) begin
          bad++;
          $display("FAIL beat4: got data=%0d idx=%0d last=%0d expected data=%0d idx=%0d last=%0d",
                   o_data4, o_idx4, o_last4, e4.d, e4.idx, e4.last);
        end else begin
          $display("beat4 data=%0d idx=%0d last=%0d ok", o_data4, o_idx4, o_last4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst20 && o_valid20) begin
      if (int'(o_idx20) > max_idx20) max_idx20 = int'(o_idx20);
      if (o_ready20) begin
        total++;
        if (o_last20) lasts20++;
        if (q20.size() == 0) begin
          bad++;
          $display("FAIL beat20 unexpected: data=%0d idx=%0d", o_data20, o_idx20);
        end else begin
          e20 = q20.pop_front();
          if (o_data20 !== e20.d || o_idx20 !== 5'(e20.idx) || o_last20 !== e20.last) begin
            bad++;
            $display("FAIL beat20: got data=%0d idx=%0d last=%0d expected data=%0d idx=%0d last=%0d",
                     o_data20, o_idx20, o_last20, e20.d, e20.idx, e20.last);
          end
        end
      end
    end
  end

  // ---------------- 4-node helpers ----------------
  task automatic pulse4(input int a, input int b, input int c, input int d, input bit expect_cap);
    zin4[0] = 24'(a);
    zin4[1] = 24'(b);
    zin4[2] = 24'(c);
    zin4[3] = 24'(d);
    i_valid4 = 1'b1;
    if (expect_cap) begin
      q4.push_back('{d: 24'(a), idx: 0, last: 1'b0});
      q4.push_back('{d: 24'(b), idx: 1, last: 1'b0});
      q4.push_back('{d: 24'(c), idx: 2, last: 1'b0});
      q4.push_back('{d: 24'(d), idx: 3, last: 1'b1});
    end
  endtask

  task automatic drain4();
    for (int i = 0; i < 50; i++) begin
      if (q4.size() == 0) break;
      step();
    end
    chk("drain4 queue left", q4.size(), 0);
  endtask

  task automatic wait_idx4(input int t);
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_valid4 && int'(o_idx4) == t) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk($sformatf("wait idx4=%0d reached", t), found, 1);
  endtask

  task automatic wait_last4();
    bit found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_last4) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait last4 reached", found, 1);
  endtask

  task automatic run4();
    // reset state
    chk("reset o_valid", o_valid4, 0);
    chk("reset o_last", o_last4, 0);
    chk("reset o_overflow", o_overflow4, 0);
    chk("reset o_idx", o_idx4, 0);
    chk("reset i_ready", i_ready4, 1);

    // basic drain
    pulse4(10, 20, 30, 40, 1'b1);
    step();
    i_valid4 = 1'b0;
    chk("latency o_valid", o_valid4, 1);
    chk("latency o_idx", o_idx4, 0);
    chk("latency o_data", o_data4, 10);
    drain4();
    chk("idle after drain o_valid", o_valid4, 0);
    chk("idle after drain i_ready", i_ready4, 1);

    // backpressure at idx 1
    pulse4(10, 20, 30, 40, 1'b1);
    step();
    i_valid4 = 1'b0;
    wait_idx4(1);
    o_ready4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall o_data", o_data4, 20);
      chk("stall o_idx", o_idx4, 1);
      chk("stall o_last", o_last4, 0);
    end
    o_ready4 = 1'b1;

    // back-to-back on the final beat
    wait_last4();
    pulse4(5, 6, 7, 8, 1'b1);
    #1;
    chk("b2b i_ready", i_ready4, 1);
    step();
    i_valid4 = 1'b0;
    chk("b2b o_valid", o_valid4, 1);
    chk("b2b o_idx", o_idx4, 0);
    chk("b2b o_data", o_data4, 5);

    // overflow at idx 2
    wait_idx4(2);
    chk("overflow i_ready", i_ready4, 0);
    pulse4(99, 99, 99, 99, 1'b0);
    step();
    i_valid4 = 1'b0;
    chk("overflow set", o_overflow4, 1);
    drain4();
    chk("overflow sticky", o_overflow4, 1);
    pulse4(1, 2, 3, 4, 1'b1);
    step();
    i_valid4 = 1'b0;
    drain4();
    chk("overflow sticky later", o_overflow4, 1);

    // reset mid-stream
    pulse4(11, 12, 13, 14, 1'b1);
    step();
    i_valid4 = 1'b0;
    wait_idx4(2);
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    q4.delete();
    chk("midrst o_valid", o_valid4, 0);
    chk("midrst o_overflow", o_overflow4, 0);
    chk("midrst i_ready", i_ready4, 1);
    pulse4(21, 22, 23, 24, 1'b1);
    step();
    i_valid4 = 1'b0;
    chk("fresh o_idx", o_idx4, 0);
    chk("fresh o_data", o_data4, 21);
    drain4();

    // reset wins over a simultaneous strobe
    rst4 = 1'b1;
    pulse4(50, 51, 52, 53, 1'b0);
    step();
    rst4 = 1'b0;
    i_valid4 = 1'b0;
    chk("rst priority o_valid", o_valid4, 0);
    step();
    chk("rst priority still idle", o_valid4, 0);
  endtask

  // ---------------- 20-node run ----------------
  task automatic run20();
    int sent = 0;
    bit drained = 1'b0;
    for (int guard = 0; guard < 80000 && sent < 1000; guard++) begin
      step();
      o_ready20 = ($urandom_range(0, 3) != 0);
      i_valid20 = 1'b0;
      #1;
      if (i_ready20) begin
        for (int k = 0; k < 20; k++) begin
          zin20[k] = 24'(sent * 100 + k);
          q20.push_back('{d: 24'(sent * 100 + k), idx: k, last: (k == 19)});
        end
        i_valid20 = 1'b1;
        sent++;
      end
    end
    step();
    i_valid20 = 1'b0;
    o_ready20 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q20.size() == 0) begin
        drained = 1'b1;
        break;
      end
      step();
    end
    chk("vectors20 sent", sent, 1000);
    chk("vectors20 drained", drained, 1);
    $display("run20 vectors=%0d lasts=%0d", sent, lasts20);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b1; rst20 = 1'b1;
    i_valid4 = 1'b0; i_valid20 = 1'b0;
    o_ready4 = 1'b1; o_ready20 = 1'b1;
    for (int k = 0; k < 4; k++) zin4[k] = '0;
    for (int k = 0; k < 20; k++) zin20[k] = '0;
    step();
    step();
    rst4 = 1'b0;
    rst20 = 1'b0;
    fork
      run4();
      run20();
    join
    chk("lasts20 count", lasts20, 1000);
    chk("max idx20 within range", (max_idx20 <= 19), 1);
    chk("overflow20 clear", o_overflow20, 0);
    chk("q4 empty at end", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Reads a full layer output vector, such as the registered post-activation vector from the ReLU layer, and streams it out one element per beat over a valid/ready interface. It sits between a parallel activation stage and a serial downstream consumer, such as the next dense layer's MAC or the output argmax stage. Upstream produces a single-cycle valid pulse with no backpressure. The block therefore captures the vector into a local buffer, drains it under downstream flow control, and flags any vector that arrives while it cannot accept one.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- DATA_WIDTH, 24, width of each element.
- NUM_NODES, 20, elements per vector; legal range is 2 or more.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  single-cycle strobe; zin holds a complete vector.
- zin  in  DATA_WIDTH x [NUM_NODES]  input vector; element 0 is sent first.
- i_ready  out  1  block can capture a vector this cycle (combinational).
- o_valid  out  1  o_data, o_idx and o_last are valid.
- o_ready  in  1  downstream accepts the current beat.
- o_data  out  DATA_WIDTH  current element.
- o_idx  out  IDX_W  index of the current element; IDX_W = $clog2(NUM_NODES).
- o_last  out  1  high on the beat with o_idx == NUM_NODES-1.
- o_overflow  out  1  sticky; set when i_valid arrives while i_ready is low.

## Operation
- States: IDLE and STREAM.
- IDLE:
  - i_ready is 1 and o_valid is 0.
  - i_valid captures zin into the buffer, clears idx to 0 and moves to STREAM.
- STREAM:
  - o_valid is 1; o_data = buf[idx]; o_last = (idx == NUM_NODES-1).
  - A beat is accepted when o_valid and o_ready are both high.
  - An accepted beat that is not last increments idx.
  - An accepted last beat moves to IDLE, unless a new capture happens in the same cycle (see back-to-back).
- Back-to-back:
  - i_ready = IDLE, or (STREAM and o_last and o_ready).
  - A capture on the final accepted beat reloads the buffer, sets idx to 0 and stays in STREAM.
  - There is no bubble between vectors.
- Stall: while o_valid is high and o_ready is low, o_data, o_idx and o_last hold stable.
- Overflow:
  - i_valid while i_ready is low is dropped; the buffer and idx are untouched.
  - o_overflow is set and stays set until rst.
- Arithmetic: idx is an IDX_W-bit counter. It never advances past NUM_NODES-1; it returns to 0 only through a capture.
- o_ready while o_valid is low has no effect.

## Timing
- Reset values:
  - state = IDLE, idx = 0, o_valid = 0, o_last = 0, o_overflow = 0.
  - o_idx = 0 and i_ready = 1 (the first cycle after rst deasserts).
  - o_data is don't-care while o_valid is 0; the buffer is not reset.
- Latency: a capture in cycle N gives o_valid = 1 with o_idx = 0 in cycle N+1.
- Throughput: one element per cycle when o_ready is held high. One vector takes NUM_NODES cycles. Sustained capacity is one vector every NUM_NODES cycles with zero gap.
- Reset mid-stream: at the next edge the state returns to IDLE and o_valid drops. The partial vector is discarded and o_overflow is cleared.
- rst takes priority over i_valid in the same cycle; no capture happens.
- i_ready depends combinationally on o_ready. Upstream must not feed i_ready back into o_ready.

## Structure
- Shared package layer_pkg holds:
  - the state enum ser_state_t {IDLE, STREAM};
  - the function idx_width(n) = $clog2(n).
- Capture buffer: instantiate the existing reg_file sub-module.
  - DATA_WIDTH = DATA_WIDTH, NUM_REGS = NUM_NODES.
  - Load enable = i_valid && i_ready.
  - The element mux buf[idx] stays in this block.
- Control: FSM, idx counter and overflow flag live in this block. No further sub-modules.

## Test plan
- Basic drain:
  - Setup: NUM_NODES = 4, o_ready held at 1; pulse i_valid with zin = {10, 20, 30, 40}.
  - Response: the cycles after the pulse show o_data 10, 20, 30, 40 with o_idx 0 to 3 and o_last on 40 only. The block is in IDLE on the following cycle.
- Backpressure:
  - Setup: as above, but drop o_ready for 3 cycles while o_idx = 1.
  - Response: o_data = 20 and o_idx = 1 hold stable across the stall; the stream resumes with 30 and no loss.
- Back-to-back:
  - Stimulus: pulse i_valid with {5, 6, 7, 8} on the cycle where the last beat (40) is accepted.
  - Response: i_ready = 1 in that cycle, and the next cycle shows o_data = 5 with o_idx = 0 and no bubble.
- Overflow:
  - Stimulus: pulse i_valid with {99, 99, 99, 99} at o_idx = 2.
  - Response: the stream continues 30, 40 unchanged; o_overflow goes to 1 and stays 1 through later vectors until rst.
- Reset mid-stream:
  - Stimulus: assert rst at o_idx = 2.
  - Response: next cycle o_valid = 0, o_overflow = 0, i_ready = 1. A fresh vector then streams from idx 0.
- Default parameters:
  - Stimulus: at NUM_NODES = 20, drive random o_ready over 1000 vectors.
  - Response: the scoreboard sees every element in order, o_last exactly once per vector, and o_idx never exceeds 19.
